// File: rtl/pipeline_control.sv
// Pipeline hazard/flow controller: decodes stage enables, flushes and PC redirect
// from a small FSM. Optional perf counters under PIPELINE_PERF_COUNTERS_EN.
module pipeline_control #(
   parameter int unsigned FLUSH_CYCLES      = 2,
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT       = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       branch_taken,
   input  logic       load_use_hazard,
   input  logic       mem_req,
   input  logic       mem_ready,
   input  logic       halt_req,
   output logic       fetch_en,
   output logic       decode_en,
   output logic       execute_en,
   output logic       memory_en,
   output logic       writeback_en,
   output logic       pc_redirect,
   output logic       flush_decode,
   output logic       flush_execute,
   output logic       halted,
   output logic       mem_error,
   output logic [2:0] state_out
`ifdef PIPELINE_PERF_COUNTERS_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);

   localparam int unsigned CNT_W = 8;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RUN      = 3'd1;
   localparam logic [2:0] FLUSH    = 3'd2;
   localparam logic [2:0] STALL    = 3'd3;
   localparam logic [2:0] MEM_WAIT = 3'd4;
   localparam logic [2:0] HALT     = 3'd5;

   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             halt_pend, halt_pend_nxt;
   logic             mem_error_nxt;
   logic             en_front, en_back;

   // State, counter, pending-halt and sticky error registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         halt_pend <= 1'b0;
         mem_error <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         halt_pend <= halt_pend_nxt;
         mem_error <= mem_error_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      halt_pend_nxt = halt_pend;
      mem_error_nxt = mem_error;
      en_front      = 1'b0;
      en_back       = 1'b0;
      pc_redirect   = 1'b0;
      flush_decode  = 1'b0;
      flush_execute = 1'b0;

      case (state)
         IDLE: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end

         RUN: begin
            if (mem_req && !mem_ready) begin
               state_nxt = MEM_WAIT;
               cnt_nxt   = CNT_ONE;
            end else if (halt_req) begin
               state_nxt = HALT;
            end else if (branch_taken) begin
               en_front      = 1'b1;
               en_back       = 1'b1;
               pc_redirect   = 1'b1;
               flush_decode  = 1'b1;
               flush_execute = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = FLUSH_INIT;
               end
            end else if (load_use_hazard) begin
               en_back       = 1'b1;
               flush_execute = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_nxt = STALL;
                  cnt_nxt   = STALL_INIT;
               end
            end else begin
               en_front = 1'b1;
               en_back  = 1'b1;
            end
         end

         // Squashed instructions: branch and hazard inputs are ignored here
         FLUSH: begin
            if (halt_req) begin
               state_nxt = HALT;
            end else begin
               en_front      = 1'b1;
               en_back       = 1'b1;
               flush_decode  = 1'b1;
               flush_execute = 1'b1;
               if (cnt <= CNT_ONE) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
         end

         STALL: begin
            if (halt_req) begin
               state_nxt = HALT;
            end else begin
               en_back       = 1'b1;
               flush_execute = 1'b1;
               if (cnt <= CNT_ONE) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
         end

         MEM_WAIT: begin
            if (halt_req) halt_pend_nxt = 1'b1;
            if (mem_ready) begin
               en_front = 1'b1;
               en_back  = 1'b1;
               cnt_nxt  = '0;
               if (halt_pend || halt_req) begin
                  state_nxt     = HALT;
                  halt_pend_nxt = 1'b0;
               end else if (branch_taken) begin
                  pc_redirect   = 1'b1;
                  flush_decode  = 1'b1;
                  flush_execute = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = FLUSH;
                     cnt_nxt   = FLUSH_INIT;
                  end else begin
                     state_nxt = RUN;
                  end
               end else begin
                  state_nxt = RUN;
               end
            end else if (cnt >= TIMEOUT) begin
               mem_error_nxt = 1'b1;
               state_nxt     = HALT;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         HALT: begin
            state_nxt = HALT;
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign fetch_en     = en_front;
   assign decode_en    = en_front;
   assign execute_en   = en_back;
   assign memory_en    = en_back;
   assign writeback_en = en_back;
   assign halted       = (state == HALT);
   assign state_out    = state;

`ifdef PIPELINE_PERF_COUNTERS_EN
   logic stall_evt, flush_evt;

   // Stall cycles: any MEM_WAIT cycle, its entry cycle, and load-use hold cycles
   assign stall_evt = (state == MEM_WAIT)
                    || ((state == RUN) && mem_req && !mem_ready)
                    || (!en_front && en_back);
   assign flush_evt = flush_decode;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_evt) stall_count <= stall_count + 32'd1;
         if (flush_evt) flush_count <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Table-driven bench for pipeline_control with an expected-output scoreboard queue.
module tb_pipeline_control;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       branch_taken = 1'b0, load_use_hazard = 1'b0;
   logic       mem_req = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
   logic       fetch_en, decode_en, execute_en, memory_en, writeback_en;
   logic       pc_redirect, flush_decode, flush_execute, halted, mem_error;
   logic [2:0] state_out;
`ifdef PIPELINE_PERF_COUNTERS_EN
   logic [31:0] stall_count, flush_count;
`endif

   pipeline_control #(
      .FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(8)
   ) dut (
      .clock(clock), .reset(reset),
      .branch_taken(branch_taken), .load_use_hazard(load_use_hazard),
      .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
      .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
      .memory_en(memory_en), .writeback_en(writeback_en),
      .pc_redirect(pc_redirect), .flush_decode(flush_decode),
      .flush_execute(flush_execute), .halted(halted), .mem_error(mem_error),
      .state_out(state_out)
`ifdef PIPELINE_PERF_COUNTERS_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   always #5 clock = ~clock;

   // in = {reset, branch_taken, load_use_hazard, mem_req, mem_ready, halt_req}
   // exp = {fetch,decode,execute,memory,writeback, pc_redirect,flush_d,flush_e, halted, mem_error, state}
   typedef struct {
      logic [5:0]  in;
      logic [12:0] exp;
   } vec_t;

   localparam logic [4:0] EN0 = 5'b00000, ALL = 5'b11111, STL = 5'b00111;
   localparam logic [2:0] F0 = 3'b000, FBR = 3'b111, FFL = 3'b011, FST = 3'b001;

   vec_t        tbl[$];
   logic [12:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;

   function automatic vec_t v(input logic [5:0] in, input logic [4:0] en, input logic [2:0] fl,
                              input logic hlt, input logic merr, input logic [2:0] st);
      vec_t r;
      r.in  = in;
      r.exp = {en, fl, hlt, merr, st};
      return r;
   endfunction

   function automatic logic [12:0] actual();
      return {fetch_en, decode_en, execute_en, memory_en, writeback_en,
              pc_redirect, flush_decode, flush_execute, halted, mem_error, state_out};
   endfunction

   task automatic apply_row(input vec_t r, input int idx);
      logic [12:0] e;
      @(negedge clock);
      {reset, branch_taken, load_use_hazard, mem_req, mem_ready, halt_req} = r.in;
      exp_q.push_back(r.exp);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (actual() !== e) begin
         failures++;
         $display("FAIL row%0d: got %b expected %b", idx, actual(), e);
      end
   endtask

   initial begin
      // Main sequence: reset, branch/flush, load-use, memory wait, pending halt
      tbl.push_back(v(6'b100000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000000, ALL, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b010000, ALL, FBR, 0, 0, 3'd1));
      tbl.push_back(v(6'b011000, ALL, FFL, 0, 0, 3'd2));
      tbl.push_back(v(6'b000000, ALL, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b001000, STL, FST, 0, 0, 3'd1));
      tbl.push_back(v(6'b000000, ALL, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b011000, ALL, FBR, 0, 0, 3'd1));
      tbl.push_back(v(6'b000000, ALL, FFL, 0, 0, 3'd2));
      tbl.push_back(v(6'b000110, ALL, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b000100, EN0, F0,  0, 0, 3'd1));
      for (int i = 0; i < 4; i++) tbl.push_back(v(6'b000100, EN0, F0, 0, 0, 3'd4));
      tbl.push_back(v(6'b000110, ALL, F0,  0, 0, 3'd4));
      tbl.push_back(v(6'b000000, ALL, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b000100, EN0, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b000101, EN0, F0,  0, 0, 3'd4));
      tbl.push_back(v(6'b000100, EN0, F0,  0, 0, 3'd4));
      tbl.push_back(v(6'b010110, ALL, F0,  0, 0, 3'd4));
      tbl.push_back(v(6'b000000, EN0, F0,  1, 0, 3'd5));
      tbl.push_back(v(6'b010000, EN0, F0,  1, 0, 3'd5));
      // After async reset: branch on MEM_WAIT exit, halt in FLUSH
      tbl.push_back(v(6'b000000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000100, EN0, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b010110, ALL, FBR, 0, 0, 3'd4));
      tbl.push_back(v(6'b000000, ALL, FFL, 0, 0, 3'd2));
      tbl.push_back(v(6'b010000, ALL, FBR, 0, 0, 3'd1));
      tbl.push_back(v(6'b000001, EN0, F0,  0, 0, 3'd2));
      tbl.push_back(v(6'b000000, EN0, F0,  1, 0, 3'd5));
      // Halt beats branch in RUN
      tbl.push_back(v(6'b100000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b010001, EN0, F0,  0, 0, 3'd1));
      tbl.push_back(v(6'b000000, EN0, F0,  1, 0, 3'd5));
      // Memory timeout after 8 wait cycles, then reset clears mem_error
      tbl.push_back(v(6'b100000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000100, EN0, F0,  0, 0, 3'd1));
      for (int i = 0; i < 8; i++) tbl.push_back(v(6'b000100, EN0, F0, 0, 0, 3'd4));
      tbl.push_back(v(6'b000100, EN0, F0,  1, 1, 3'd5));
      tbl.push_back(v(6'b100000, EN0, F0,  0, 0, 3'd0));
      tbl.push_back(v(6'b000000, EN0, F0,  0, 0, 3'd0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply_row(tbl[i], i);
         if (i == 23) begin
            // Reset asserted mid-cycle while halted must clear state before any edge
            #1 reset = 1'b1;
            #1;
            checks++;
            if (state_out !== 3'd0 || halted !== 1'b0 || fetch_en !== 1'b0 || execute_en !== 1'b0) begin
               failures++;
               $display("FAIL async_reset: state=%0d halted=%b expected state=0 halted=0",
                        state_out, halted);
            end
         end
      end

`ifdef PIPELINE_PERF_COUNTERS_EN
      apply_row(v(6'b100000, EN0, F0,  0, 0, 3'd0), 100);
      apply_row(v(6'b000000, EN0, F0,  0, 0, 3'd0), 101);
      apply_row(v(6'b010000, ALL, FBR, 0, 0, 3'd1), 102);
      apply_row(v(6'b000000, ALL, FFL, 0, 0, 3'd2), 103);
      apply_row(v(6'b000100, EN0, F0,  0, 0, 3'd1), 104);
      apply_row(v(6'b000100, EN0, F0,  0, 0, 3'd4), 105);
      apply_row(v(6'b000110, ALL, F0,  0, 0, 3'd4), 106);
      apply_row(v(6'b000000, ALL, F0,  0, 0, 3'd1), 107);
      checks++;
      if (flush_count !== 32'd2 || stall_count !== 32'd3) begin
         failures++;
         $display("FAIL perf_counters: flush=%0d stall=%0d expected flush=2 stall=3",
                  flush_count, stall_count);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
